// File: rtl/water_pump_pkg.sv
// Shared types and helpers for the tank-fill pump sequencer.
package water_pump_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILLING = 2'd1,
    HOLDOFF = 2'd2,
    FAULT   = 2'd3
  } pump_state_t;

  localparam int unsigned LEVEL_W  = 3;
  localparam int unsigned N_PROBES = 5;

  // Count of wet probes contiguous from the bottom probe upwards.
  function automatic logic [LEVEL_W-1:0] thermo_level(input logic [N_PROBES-1:0] db);
    logic [LEVEL_W-1:0] n;
    logic               run;
    n   = '0;
    run = 1'b1;
    for (int unsigned i = 0; i < N_PROBES; i++) begin
      if (run && db[i]) n = n + LEVEL_W'(1);
      else              run = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/water_pump_sequencer_probe_debounce.sv
// One level probe: 2-flop synchroniser, active-low inversion and debounce filter.
module probe_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_n,
  output logic wet
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic             wet_raw;
  logic [CNT_W-1:0] cnt;

  assign wet_raw = ~sync[1];

  // Synchroniser resets to the idle-high (dry) pin level so it agrees with wet=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
      cnt  <= '0;
      wet  <= 1'b0;
    end else begin
      sync <= {sync[0], raw_n};
      if (wet_raw != wet) begin
        if (cnt == CNT_LAST) begin
          wet <= wet_raw;
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/water_pump_sequencer.sv
// Tank-fill pump controller: debounced probes, level encoder, hysteresis FSM with watchdog.
// Optional macro LEVEL_CONSISTENCY_CHECK_EN faults on a persistent non-thermometer probe pattern.
module water_pump_sequencer
  import water_pump_pkg::*;
#(
  parameter int unsigned N_SENSORS       = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned LOW_LEVEL       = 1,
  parameter int unsigned HIGH_LEVEL      = 4,
  parameter int unsigned MIN_OFF_CYCLES  = 250000,
  parameter int unsigned MAX_RUN_CYCLES  = 50000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SENSORS-1:0] sensor_n,
  input  logic                 enable,
  input  logic                 fault_clr,
  output logic                 pump_on,
  output logic [LEVEL_W-1:0]   level,
  output logic [N_SENSORS-1:0] led,
  output logic [1:0]           state,
  output logic                 fault
);

  localparam int unsigned RUN_W = (MAX_RUN_CYCLES > 1) ? $clog2(MAX_RUN_CYCLES) : 1;
  localparam int unsigned OFF_W = (MIN_OFF_CYCLES > 1) ? $clog2(MIN_OFF_CYCLES) : 1;
  localparam logic [RUN_W-1:0]   RUN_LAST = RUN_W'(MAX_RUN_CYCLES - 1);
  localparam logic [OFF_W-1:0]   OFF_LAST = OFF_W'(MIN_OFF_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LOW_L    = LEVEL_W'(LOW_LEVEL);
  localparam logic [LEVEL_W-1:0] HIGH_L   = LEVEL_W'(HIGH_LEVEL);

  logic [N_SENSORS-1:0] db;
  pump_state_t          state_q, state_d;
  logic [RUN_W-1:0]     run_cnt;
  logic [OFF_W-1:0]     off_cnt;
  logic                 incon;
  logic                 clr_ok;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_probe
    probe_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_probe (
      .clk   (clk),
      .rst_n (rst_n),
      .raw_n (sensor_n[g]),
      .wet   (db[g])
    );
  end

  assign led   = db;
  assign level = thermo_level(db);
  assign state = state_q;

`ifdef LEVEL_CONSISTENCY_CHECK_EN
  localparam int unsigned BAD_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(DEBOUNCE_CYCLES - 1);

  logic [N_SENSORS-1:0] thermo_mask;
  logic                 non_thermo;
  logic [BAD_W-1:0]     bad_cnt;

  always_comb begin
    thermo_mask = '0;
    for (int unsigned i = 0; i < N_SENSORS; i++) begin
      if (LEVEL_W'(i) < level) thermo_mask[i] = 1'b1;
    end
  end

  assign non_thermo = (db != thermo_mask);

  // bad_cnt holds the number of earlier consecutive bad cycles, saturating at D-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               bad_cnt <= '0;
    else if (!non_thermo)     bad_cnt <= '0;
    else if (bad_cnt != BAD_LAST) bad_cnt <= bad_cnt + BAD_W'(1);
  end

  assign incon  = non_thermo && (bad_cnt == BAD_LAST);
  assign clr_ok = fault_clr && !non_thermo;
`else
  assign incon  = 1'b0;
  assign clr_ok = fault_clr;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (incon)                          state_d = FAULT;
        else if (enable && (level < LOW_L)) state_d = FILLING;
      end
      FILLING: begin
        if ((run_cnt == RUN_LAST) || incon)     state_d = FAULT;
        else if ((level >= HIGH_L) || !enable)  state_d = HOLDOFF;
      end
      HOLDOFF: begin
        if (off_cnt == OFF_LAST) state_d = IDLE;
      end
      FAULT: begin
        if (clr_ok) state_d = HOLDOFF;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pump_on <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      pump_on <= (state_d == FILLING);
      fault   <= (state_d == FAULT);
    end
  end

  // Holding each counter at zero outside its state gives the clear-on-entry behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      off_cnt <= '0;
    end else begin
      if (state_q != FILLING)  run_cnt <= '0;
      else if (run_cnt != '1)  run_cnt <= run_cnt + RUN_W'(1);
      if (state_q != HOLDOFF)  off_cnt <= '0;
      else if (off_cnt != '1)  off_cnt <= off_cnt + OFF_W'(1);
    end
  end

endmodule

// File: tb/tb_water_pump_sequencer.sv
// Bench for water_pump_sequencer: vector table, corner sequences and random stimulus vs a reference model.
module tb_water_pump_sequencer;

  localparam int D    = 4;
  localparam int OFF  = 8;
  localparam int RUN  = 40;
  localparam int LOW  = 1;
  localparam int HIGH = 4;
`ifdef LEVEL_CONSISTENCY_CHECK_EN
  localparam bit CONSIST = 1'b1;
`else
  localparam bit CONSIST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] sensor_n;
  logic       enable;
  logic       fault_clr;
  logic       pump_on;
  logic [2:0] level;
  logic [4:0] led;
  logic [1:0] state;
  logic       fault;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  water_pump_sequencer #(
    .N_SENSORS      (5),
    .DEBOUNCE_CYCLES(D),
    .LOW_LEVEL      (LOW),
    .HIGH_LEVEL     (HIGH),
    .MIN_OFF_CYCLES (OFF),
    .MAX_RUN_CYCLES (RUN)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sensor_n (sensor_n),
    .enable   (enable),
    .fault_clr(fault_clr),
    .pump_on  (pump_on),
    .level    (level),
    .led      (led),
    .state    (state),
    .fault    (fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_state, m_time, m_lvl, m_nxt, m_streak;
  logic [4:0] m_db, m_s1, m_s2, m_wet;
  int         m_cnt [5];
  bit         m_bad, m_incon;

  function automatic int thermo(input logic [4:0] v);
    int n = 0;
    while (n < 5 && v[n]) n++;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_time = 0; m_streak = 0;
      m_db = '0; m_s1 = '1; m_s2 = '1;
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    end else begin
      m_lvl    = thermo(m_db);
      m_bad    = ($countones(m_db) != m_lvl);
      m_streak = m_bad ? m_streak + 1 : 0;
      m_incon  = CONSIST && (m_streak >= D);
      m_nxt    = m_state;
      case (m_state)
        0: if (m_incon) m_nxt = 3;
           else if (enable && m_lvl < LOW) m_nxt = 1;
        1: if (m_time + 1 >= RUN || m_incon) m_nxt = 3;
           else if (m_lvl >= HIGH || !enable) m_nxt = 2;
        2: if (m_time + 1 >= OFF) m_nxt = 0;
        default: if (fault_clr && !(CONSIST && m_bad)) m_nxt = 2;
      endcase
      m_time = (m_nxt == m_state) ? m_time + 1 : 0;
      m_state = m_nxt;
      m_wet = ~m_s2;
      for (int i = 0; i < 5; i++) begin
        if (m_wet[i] != m_db[i]) begin
          m_cnt[i]++;
          if (m_cnt[i] == D) begin
            m_db[i]  = m_wet[i];
            m_cnt[i] = 0;
          end
        end else begin
          m_cnt[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = sensor_n;
    end
  end

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      check("mdl_state", state,   m_state);
      check("mdl_pump",  pump_on, (m_state == 1));
      check("mdl_fault", fault,   (m_state == 3));
      check("mdl_level", level,   thermo(m_db));
      check("mdl_led",   led,     m_db);
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0] sn;
    logic       en;
    logic       clr;
    int         hold;
    logic [1:0] st;
    logic       pump;
    logic       flt;
    logic [2:0] lvl;
    logic [4:0] ld;
  } vec_t;

  vec_t vecs [24];

  task automatic apply(input vec_t v, input int idx);
    sensor_n  = v.sn;
    enable    = v.en;
    fault_clr = v.clr;
    repeat (v.hold) @(negedge clk);
    check($sformatf("v%0d_state", idx), state,   v.st);
    check($sformatf("v%0d_pump",  idx), pump_on, v.pump);
    check($sformatf("v%0d_fault", idx), fault,   v.flt);
    check($sformatf("v%0d_level", idx), level,   v.lvl);
    check($sformatf("v%0d_led",   idx), led,     v.ld);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] p;
    int         hold, lvl_r, bit_r;

    vecs[0]  = '{5'b11111, 1, 0,  1, 2'd1, 1, 0, 3'd0, 5'b00000};
    vecs[1]  = '{5'b11110, 1, 0,  6, 2'd1, 1, 0, 3'd1, 5'b00001};
    vecs[2]  = '{5'b11100, 1, 0,  6, 2'd1, 1, 0, 3'd2, 5'b00011};
    vecs[3]  = '{5'b11000, 1, 0,  6, 2'd1, 1, 0, 3'd3, 5'b00111};
    vecs[4]  = '{5'b10000, 1, 0,  6, 2'd1, 1, 0, 3'd4, 5'b01111};
    vecs[5]  = '{5'b10000, 1, 0,  1, 2'd2, 0, 0, 3'd4, 5'b01111};
    vecs[6]  = '{5'b10000, 1, 0,  7, 2'd2, 0, 0, 3'd4, 5'b01111};
    vecs[7]  = '{5'b10000, 1, 0,  1, 2'd0, 0, 0, 3'd4, 5'b01111};
    vecs[8]  = '{5'b10001, 1, 0,  2, 2'd0, 0, 0, 3'd4, 5'b01111};
    vecs[9]  = '{5'b10000, 1, 0,  6, 2'd0, 0, 0, 3'd4, 5'b01111};
    vecs[10] = '{5'b11111, 1, 0,  6, 2'd0, 0, 0, 3'd0, 5'b00000};
    vecs[11] = '{5'b11111, 1, 0,  1, 2'd1, 1, 0, 3'd0, 5'b00000};
    vecs[12] = '{5'b11111, 1, 0, 39, 2'd1, 1, 0, 3'd0, 5'b00000};
    vecs[13] = '{5'b11111, 1, 0,  1, 2'd3, 0, 1, 3'd0, 5'b00000};
    vecs[14] = '{5'b11111, 1, 0,  3, 2'd3, 0, 1, 3'd0, 5'b00000};
    vecs[15] = '{5'b11111, 1, 1,  1, 2'd2, 0, 0, 3'd0, 5'b00000};
    vecs[16] = '{5'b11111, 1, 0,  7, 2'd2, 0, 0, 3'd0, 5'b00000};
    vecs[17] = '{5'b11111, 1, 0,  1, 2'd0, 0, 0, 3'd0, 5'b00000};
    vecs[18] = '{5'b11111, 1, 0,  1, 2'd1, 1, 0, 3'd0, 5'b00000};
    vecs[19] = '{5'b11111, 0, 0,  1, 2'd2, 0, 0, 3'd0, 5'b00000};
    vecs[20] = '{5'b11111, 0, 0,  7, 2'd2, 0, 0, 3'd0, 5'b00000};
    vecs[21] = '{5'b11111, 0, 0,  1, 2'd0, 0, 0, 3'd0, 5'b00000};
    vecs[22] = '{5'b11111, 0, 0, 10, 2'd0, 0, 0, 3'd0, 5'b00000};
    vecs[23] = '{5'b11111, 0, 1,  1, 2'd0, 0, 0, 3'd0, 5'b00000};

    rst_n     = 1'b0;
    sensor_n  = 5'b11111;
    enable    = 1'b1;
    fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_state", state,   2'd0);
    check("rst_pump",  pump_on, 1'b0);
    check("rst_fault", fault,   1'b0);
    check("rst_level", level,   3'd0);
    check("rst_led",   led,     5'b00000);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 24; i++) apply(vecs[i], i);

    // Asynchronous reset in the middle of a fill.
    enable = 1'b1;
    @(negedge clk);
    check("midfill_pump_pre", pump_on, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midfill_pump_rst",  pump_on, 1'b0);
    check("midfill_state_rst", state,   2'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Watchdog expiry and enable drop on the same cycle: watchdog wins.
    @(negedge clk);
    check("prio_fill", state, 2'd1);
    repeat (RUN - 1) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("prio_state", state, 2'd3);
    check("prio_fault", fault, 1'b1);
    enable = 1'b1;

`ifdef LEVEL_CONSISTENCY_CHECK_EN
    do_reset();
    sensor_n = 5'b11011;
    repeat (7) @(negedge clk);
    check("cons_level", level, 3'd0);
    repeat (8) @(negedge clk);
    check("cons_fault_state", state, 2'd3);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("cons_clr_ignored", state, 2'd3);
    sensor_n = 5'b11111;
    repeat (8) @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    check("cons_clr_taken", state, 2'd2);
`endif

    // Randomised stimulus, mostly thermometer patterns with occasional bit flips.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      lvl_r = $urandom_range(0, 5);
      p     = 5'b11111 << lvl_r;
      if ($urandom_range(0, 5) == 0) begin
        bit_r    = $urandom_range(0, 4);
        p[bit_r] = ~p[bit_r];
      end
      sensor_n  = p;
      enable    = ($urandom_range(0, 9) != 0);
      fault_clr = ($urandom_range(0, 7) == 0);
      hold      = $urandom_range(1, 12);
      @(negedge clk);
      fault_clr = 1'b0;
      repeat (hold - 1) @(negedge clk);
    end

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/water_pump_sequencer.md
Name: water_pump_sequencer

Overview:
- Controls the tank-fill pump from the 5 transistor moisture/level probes. Probes are active-low open-collector inputs, and sensor 0 is the lowest probe.
- Synchronises and debounces each probe, then derives a tank level (0..5).
- Runs a hysteresis pump FSM with a minimum-off hold and a maximum-run watchdog.
- Drives the per-probe LEDs and the pump enable. Sits between the board I/O pins and the pump driver transistor.

Parameters:
- N_SENSORS, 5, number of level probes (fixed at 5 for this board; other values are not required).
- DEBOUNCE_CYCLES, 50000, clock cycles a synchronised probe must hold a new value before it is accepted (1 ms at 50 MHz).
- LOW_LEVEL, 1, pump starts when level < LOW_LEVEL.
- HIGH_LEVEL, 4, pump stops when level >= HIGH_LEVEL. Must satisfy LOW_LEVEL < HIGH_LEVEL <= N_SENSORS.
- MIN_OFF_CYCLES, 250000, minimum pump-off time after any stop.
- MAX_RUN_CYCLES, 50000000, watchdog limit on continuous pump run.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low.
- sensor_n  input  N_SENSORS  raw probe collectors; 0 = wet. Asynchronous to clk.
- enable  input  1  1 = automatic control allowed; 0 forces the pump off.
- fault_clr  input  1  single-cycle pulse; clears a latched fault.
- pump_on  output  1  1 = pump driver active.
- level  output  3  debounced tank level, 0..5.
- led  output  N_SENSORS  debounced wet flags; led[i] = 1 when probe i is wet.
- state  output  2  FSM state code, for debug.
- fault  output  1  latched watchdog/consistency fault.

Behaviour:
- Reset values:
  - pump_on=0, level=0, led=0, fault=0, state=IDLE.
  - Debounced flags = 0 (dry); all counters = 0.
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n. All flops are asynchronously cleared.
- Input conditioning:
  - Each sensor_n bit passes through a 2-flop synchroniser, then is inverted to give wet_raw[i].
  - Per-probe debounce counter:
    - If wet_raw[i] != db[i], count up; when the count reaches DEBOUNCE_CYCLES-1, db[i] takes wet_raw[i] and the counter clears.
    - If wet_raw[i] == db[i], the counter clears.
  - Latency from pin change to led change = 2 + DEBOUNCE_CYCLES cycles.
- led = db, registered.
- level = number of consecutive wet probes starting at probe 0. Example: db=5'b00111 gives level 3; db=5'b00101 gives level 1.
- FSM states (state encoding): IDLE=0, FILLING=1, HOLDOFF=2, FAULT=3.
  - IDLE: pump_on=0.
    - Go to FILLING when enable=1 and level < LOW_LEVEL.
  - FILLING: pump_on=1; run_cnt increments each cycle.
    - Go to HOLDOFF when level >= HIGH_LEVEL or enable=0.
    - Go to FAULT when run_cnt reaches MAX_RUN_CYCLES-1. This transition has priority over HOLDOFF when both occur in the same cycle.
  - HOLDOFF: pump_on=0; off_cnt increments each cycle.
    - Go to IDLE when off_cnt reaches MIN_OFF_CYCLES-1.
    - enable and level are ignored while in HOLDOFF.
  - FAULT: pump_on=0, fault=1.
    - Go to HOLDOFF on fault_clr=1, and clear fault in the same transition.
- run_cnt clears on entry to FILLING; off_cnt clears on entry to HOLDOFF. Both counters saturate and never wrap.
- pump_on is a registered decode of the next state: it rises the cycle after the IDLE->FILLING decision and falls the cycle FILLING is left.
- fault_clr outside FAULT has no effect.
- Reset mid-fill drops pump_on immediately (asynchronous clear).

Optional Feature:
- Macro: LEVEL_CONSISTENCY_CHECK_EN.
- When defined:
  - A non-thermometer db pattern (any wet probe above a dry probe) that persists for DEBOUNCE_CYCLES consecutive cycles is treated as a fault.
  - In IDLE or FILLING this forces FAULT and sets fault.
  - fault_clr is honoured only once the pattern is gone; otherwise the FSM stays in FAULT.
- When undefined: no consistency logic is built, and level is computed as specified without it.

Decomposition:
- Package water_pump_pkg:
  - typedef enum logic [1:0] pump_state_t {IDLE, FILLING, HOLDOFF, FAULT}.
  - Constant LEVEL_W = 3.
  - Function thermo_level(db) returning the contiguous-from-bottom count.
- Sub-module probe_debounce: one instance per probe, containing the synchroniser, the inversion and the debounce counter. Parameter DEBOUNCE_CYCLES; ports clk, rst_n, raw_n, wet.
- Top level: probe_debounce instances, level encoder, FSM, counters, and the optional consistency check.

Test Plan (bench overrides DEBOUNCE_CYCLES=4, MIN_OFF_CYCLES=8, MAX_RUN_CYCLES=40):
- Reset, all probes dry (sensor_n=5'b11111), enable=1 → level=0; FILLING entered after debounce; pump_on=1 within 1 cycle of the decision.
- Fill sequence, sensor_n stepping 11110, 11100, 11000, 10000 → level reaches 4; pump_on falls; HOLDOFF for 8 cycles, then IDLE.
- 2-cycle glitch on sensor_n[0] → led[0] and level unchanged.
- Probes held dry for >40 cycles in FILLING → FAULT, fault=1, pump_on=0; fault_clr pulse → HOLDOFF, fault=0, then IDLE, then FILLING again.
- enable dropped mid-fill → HOLDOFF next cycle, pump_on=0. With enable=0 in IDLE, FILLING is never entered.
- (LEVEL_CONSISTENCY_CHECK_EN) sensor_n=5'b11011, i.e. probe 2 wet alone → level=0; FAULT after debounce plus 4 cycles; fault_clr is ignored until the pattern clears.
